ddr3_frame_reader: RTL and testbench



---
 rtl/ddr3_ctrl_pkg.sv | 25 ++
 rtl/ddr3_frame_reader.sv | 196 +++++++++++++++++++
 tb/tb_ddr3_frame_reader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_ctrl_pkg
// Shared definitions for the DDR3 frame-buffer control slice: the frame
// reader FSM state type and the default geometry constants used by the
// register block and the frame reader.
// ---------------------------------------------------------------------------
package ddr3_ctrl_pkg;

  // Frame reader FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rd_state_t;

  // Default geometry: 26-bit word addresses, 640x480 one-word pixels
  localparam int DDR_ADDR_W      = 26;
  localparam int DDR_BURST_LEN   = 16;
  localparam int DDR_FRAME_WORDS = 307200;

  // Width of the pixel FIFO free-space count
  localparam int FIFO_SPACE_W    = 16;

endpackage : ddr3_ctrl_pkg

// File: rtl/ddr3_frame_reader.sv
// ---------------------------------------------------------------------------
// ddr3_frame_reader
// Avalon-MM burst read master that drains the ping-pong DDR3 frame buffers
// into the VGA pixel FIFO. Buffers are served in strict alternation; a frame
// is fetched in bursts of at most BURST_LEN words, every word is forwarded
// one cycle after its readdatavalid beat, and the buffer's clear line pulses
// for one cycle together with the last word of the frame.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   buffer0/1_empty                per-buffer empty flags (0 = frame ready)
//   buffer0/1_offset               frame base word address per buffer
//   clear_buffer0/1                one-cycle pulse when a frame is consumed
//   avm_address/read/burstcount    Avalon burst read request
//   avm_waitrequest                slave stall
//   avm_readdata/readdatavalid     returned read beats
//   fifo_space                     free words in the pixel FIFO
//   pix_data/valid/sof/eof/buf     registered pixel stream to the FIFO
// ---------------------------------------------------------------------------
module ddr3_frame_reader
  import ddr3_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DDR_ADDR_W,
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = DDR_BURST_LEN,
  parameter int FRAME_WORDS = DDR_FRAME_WORDS,
  parameter int BC_W        = 7
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    buffer0_empty,
  input  logic                    buffer1_empty,
  input  logic [ADDR_W-1:0]       buffer0_offset,
  input  logic [ADDR_W-1:0]       buffer1_offset,
  output logic                    clear_buffer0,
  output logic                    clear_buffer1,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_read,
  output logic [BC_W-1:0]         avm_burstcount,
  input  logic                    avm_waitrequest,
  input  logic [DATA_W-1:0]       avm_readdata,
  input  logic                    avm_readdatavalid,
  input  logic [FIFO_SPACE_W-1:0] fifo_space,
  output logic [DATA_W-1:0]       pix_data,
  output logic                    pix_valid,
  output logic                    pix_sof,
  output logic                    pix_eof,
  output logic                    pix_buf
);

  localparam int WC_W = $clog2(FRAME_WORDS + 1);

  rd_state_t           r_state;
  rd_state_t           w_state_nxt;

  logic                r_cur_buf;
  logic [ADDR_W-1:0]   r_base;
  logic [WC_W-1:0]     r_word_cnt;
  logic [BC_W-1:0]     r_beat_cnt;

  logic                r_read;
  logic [ADDR_W-1:0]   r_address;
  logic [BC_W-1:0]     r_burstcount;

  logic [DATA_W-1:0]   r_pix_data;
  logic                r_pix_valid;
  logic                r_pix_sof;
  logic                r_pix_eof;
  logic                r_pix_buf;
  logic                r_clear0;
  logic                r_clear1;

  logic                w_cur_empty;
  logic [ADDR_W-1:0]   w_cur_offset;
  logic [WC_W-1:0]     w_remain;
  logic [BC_W-1:0]     w_len;
  logic                w_space_ok;
  logic                w_accept;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_frame_end;

  assign w_cur_empty  = r_cur_buf ? buffer1_empty  : buffer0_empty;
  assign w_cur_offset = r_cur_buf ? buffer1_offset : buffer0_offset;

  // Burst length is the smaller of BURST_LEN and the words left in the
  // frame; compared at int width so BURST_LEN > FRAME_WORDS still works.
  assign w_remain   = WC_W'(FRAME_WORDS) - r_word_cnt;
  assign w_len      = (int'(w_remain) < BURST_LEN) ? BC_W'(w_remain) : BC_W'(BURST_LEN);
  assign w_space_ok = int'(fifo_space) >= int'(w_len);

  assign w_accept    = r_read & ~avm_waitrequest;
  // Beats are only meaningful while a burst is outstanding; stray
  // readdatavalid in any other state is dropped here.
  assign w_beat      = (r_state == DATA) & avm_readdatavalid;
  assign w_last_beat = w_beat & (r_beat_cnt == BC_W'(1));
  assign w_frame_end = w_last_beat & (r_word_cnt == WC_W'(FRAME_WORDS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (!w_cur_empty) w_state_nxt = REQ;
      REQ:  if (w_accept)     w_state_nxt = DATA;
      DATA: if (w_last_beat)  w_state_nxt = w_frame_end ? DONE : REQ;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_buf    <= 1'b0;
      r_base       <= '0;
      r_word_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_read       <= 1'b0;
      r_address    <= '0;
      r_burstcount <= '0;
      r_pix_data   <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_sof    <= 1'b0;
      r_pix_eof    <= 1'b0;
      r_pix_buf    <= 1'b0;
      r_clear0     <= 1'b0;
      r_clear1     <= 1'b0;
    end else begin
      r_clear0    <= 1'b0;
      r_clear1    <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_sof   <= 1'b0;
      r_pix_eof   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_cur_empty) begin
            r_base     <= w_cur_offset;
            r_word_cnt <= '0;
          end
        end
        REQ: begin
          if (!r_read) begin
            // Raise the request only once the FIFO can absorb the whole
            // burst, since the pixel stream has no backpressure.
            if (w_space_ok) begin
              r_read       <= 1'b1;
              r_address    <= r_base + ADDR_W'(r_word_cnt);
              r_burstcount <= w_len;
            end
          end else if (!avm_waitrequest) begin
            r_read     <= 1'b0;
            r_beat_cnt <= r_burstcount;
          end
        end
        DATA: begin
          if (avm_readdatavalid) begin
            r_beat_cnt  <= r_beat_cnt - BC_W'(1);
            r_word_cnt  <= r_word_cnt + WC_W'(1);
            r_pix_data  <= avm_readdata;
            r_pix_valid <= 1'b1;
            r_pix_sof   <= (r_word_cnt == '0);
            r_pix_eof   <= (r_word_cnt == WC_W'(FRAME_WORDS - 1));
            r_pix_buf   <= r_cur_buf;
            // Clear goes out alongside the last word of the frame.
            if (w_frame_end) begin
              r_clear0 <= ~r_cur_buf;
              r_clear1 <= r_cur_buf;
            end
          end
        end
        DONE: begin
          r_cur_buf <= ~r_cur_buf;
        end
        default: ;
      endcase
    end
  end

  assign clear_buffer0  = r_clear0;
  assign clear_buffer1  = r_clear1;
  assign avm_address    = r_address;
  assign avm_read       = r_read;
  assign avm_burstcount = r_burstcount;
  assign pix_data       = r_pix_data;
  assign pix_valid      = r_pix_valid;
  assign pix_sof        = r_pix_sof;
  assign pix_eof        = r_pix_eof;
  assign pix_buf        = r_pix_buf;

endmodule : ddr3_frame_reader

// File: tb/tb_ddr3_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_ddr3_frame_reader
// Directed bench for ddr3_frame_reader with FRAME_WORDS=40, BURST_LEN=16.
// A behavioural Avalon slave returns pat(address) for each beat; expected
// pixels and bursts are queued when a frame is started and compared as the
// DUT produces them.
// ---------------------------------------------------------------------------
module tb_ddr3_frame_reader;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int BLEN   = 16;
  localparam int FW     = 40;
  localparam int BC_W   = 7;

  logic              clk;
  logic              reset_n;
  logic              buffer0_empty, buffer1_empty;
  logic [ADDR_W-1:0] buffer0_offset, buffer1_offset;
  logic              clear_buffer0, clear_buffer1;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [BC_W-1:0]   avm_burstcount;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic [15:0]       fifo_space;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid, pix_sof, pix_eof, pix_buf;

  ddr3_frame_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BLEN), .FRAME_WORDS(FW), .BC_W(BC_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .buffer0_empty(buffer0_empty), .buffer1_empty(buffer1_empty),
    .buffer0_offset(buffer0_offset), .buffer1_offset(buffer1_offset),
    .clear_buffer0(clear_buffer0), .clear_buffer1(clear_buffer1),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .fifo_space(fifo_space),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_eof(pix_eof), .pix_buf(pix_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a);
    return {a[5:0], a} ^ 32'h5A5A_1234;
  endfunction

  // Scoreboards: {buf, sof, eof, data} per pixel and {addr, burstcount} per burst
  logic [34:0]       exp_pix[$];
  logic [32:0]       exp_burst[$];
  logic [ADDR_W-1:0] bq[$];

  int stall_idx = -1;
  bit gap_en    = 1'b0;
  bit stray_en  = 1'b0;

  int n_accept = 0, n_read_cycles = 0, cur_stall = 0;
  int pix_cnt = 0, clr0_cnt = 0, clr1_cnt = 0;

  task automatic exp_frame(input logic b, input logic [ADDR_W-1:0] off);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < FW; i++) begin
      a = off + ADDR_W'(i);
      exp_pix.push_back({b, (i == 0), (i == FW - 1), pat(a)});
    end
    for (int w = 0; w < FW; w += BLEN) begin
      a = off + ADDR_W'(w);
      exp_burst.push_back({a, BC_W'(((FW - w) < BLEN) ? (FW - w) : BLEN)});
    end
  endtask

  task automatic wait_clr(input bit which, input int target);
    for (int i = 0; i < 600; i++) begin
      if ((which ? clr1_cnt : clr0_cnt) >= target) break;
      @(negedge clk);
    end
    chk(which ? "clr1_count" : "clr0_count", 64'(which ? clr1_cnt : clr0_cnt), 64'(target));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural Avalon slave: beats of an accepted burst start the cycle
  // after acceptance; optional random gaps, stray beats and stalls.
  initial begin : slave
    logic [ADDR_W-1:0] seen_addr;
    logic [BC_W-1:0]   seen_bc;
    bit                req_seen;
    req_seen = 1'b0;
    seen_addr = '0;
    seen_bc = '0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bq.delete();
        req_seen = 1'b0;
        cur_stall = 0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        continue;
      end
      avm_readdatavalid = 1'b0;
      if (bq.size() > 0) begin
        if (!(gap_en && $urandom_range(0, 2) == 0)) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = pat(bq.pop_front());
        end
      end else if (stray_en) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hDEAD_BEEF;
      end
      avm_waitrequest = 1'b0;
      if (avm_read) begin
        n_read_cycles++;
        if (!req_seen) begin
          req_seen = 1'b1;
          seen_addr = avm_address;
          seen_bc = avm_burstcount;
          chk("one_outstanding", 64'(bq.size()), 64'(0));
          if (exp_burst.size() == 0) chk("burst_unexpected", 64'(1), 64'(0));
          else chk("burst", 64'({seen_addr, seen_bc}), 64'(exp_burst.pop_front()));
        end else begin
          chk("burst_stable", 64'({avm_address, avm_burstcount}), 64'({seen_addr, seen_bc}));
        end
        if (n_accept == stall_idx && cur_stall < 5) begin
          avm_waitrequest = 1'b1;
          cur_stall++;
        end else begin
          for (int k = 0; k < int'(avm_burstcount); k++) bq.push_back(avm_address + ADDR_W'(k));
          n_accept++;
          req_seen = 1'b0;
          cur_stall = 0;
        end
      end
    end
  end

  // Output monitor: pixel scoreboard and clear-pulse checks
  initial begin : mon
    bit prev0, prev1;
    prev0 = 1'b0;
    prev1 = 1'b0;
    forever begin
      @(negedge clk);
      if (pix_valid) begin
        pix_cnt++;
        if (exp_pix.size() == 0) chk("pix_unexpected", 64'(1), 64'(0));
        else chk("pix", 64'({pix_buf, pix_sof, pix_eof, pix_data}), 64'(exp_pix.pop_front()));
      end
      if (clear_buffer0 || clear_buffer1) begin
        chk("clr_with_eof", 64'({pix_valid, pix_eof, clear_buffer0 & clear_buffer1}), 64'(3'b110));
        chk("clr_buf", 64'(pix_buf), 64'(clear_buffer1));
        chk("clr_one_cycle", 64'({clear_buffer0 & prev0, clear_buffer1 & prev1}), 64'(0));
      end
      if (clear_buffer0) clr0_cnt++;
      if (clear_buffer1) clr1_cnt++;
      prev0 = clear_buffer0;
      prev1 = clear_buffer1;
    end
  end

  initial begin : main
    int rc0, acc0, pc0, c0;
    reset_n = 1'b0;
    buffer0_empty = 1'b1;
    buffer1_empty = 1'b1;
    buffer0_offset = '0;
    buffer1_offset = '0;
    fifo_space = 16'd64;
    idle(3);
    chk("reset_outputs",
        64'({clear_buffer0, clear_buffer1, avm_read, avm_address, avm_burstcount,
             pix_valid, pix_sof, pix_eof, pix_buf, pix_data}), 64'(0));
    reset_n = 1'b1;
    idle(2);

    // Single frame on buffer 0
    buffer0_offset = 26'h100;
    exp_frame(1'b0, 26'h100);
    buffer0_empty = 1'b0;
    wait_clr(1'b0, 1);
    buffer0_empty = 1'b1;
    idle(5);
    chk("frame1_pix_count", 64'(pix_cnt), 64'(FW));
    chk("frame1_bursts", 64'(n_accept), 64'(3));

    // Buffer 0 refilled while buffer 1 is current: must wait
    rc0 = n_read_cycles;
    buffer0_offset = 26'h200;
    buffer0_empty = 1'b0;
    idle(30);
    chk("alternation_wait", 64'(n_read_cycles), 64'(rc0));
    // Ping-pong: buffer 1 then buffer 0
    buffer1_offset = 26'h2000;
    exp_frame(1'b1, 26'h2000);
    exp_frame(1'b0, 26'h200);
    buffer1_empty = 1'b0;
    wait_clr(1'b1, 1);
    buffer1_empty = 1'b1;
    wait_clr(1'b0, 2);
    buffer0_empty = 1'b1;
    rc0 = n_read_cycles;
    idle(60);
    chk("no_third_frame", 64'(n_read_cycles), 64'(rc0));
    chk("pingpong_pix_count", 64'(pix_cnt), 64'(3 * FW));

    // Backpressure then waitrequest on buffer 1
    rc0 = n_read_cycles;
    acc0 = n_accept;
    stall_idx = n_accept;
    fifo_space = 16'd15;
    buffer1_offset = 26'h3000;
    exp_frame(1'b1, 26'h3000);
    buffer1_empty = 1'b0;
    idle(20);
    chk("fifo_stall_read", 64'(avm_read), 64'(0));
    chk("fifo_stall_cycles", 64'(n_read_cycles), 64'(rc0));
    fifo_space = 16'd16;
    wait_clr(1'b1, 2);
    buffer1_empty = 1'b1;
    stall_idx = -1;
    fifo_space = 16'd64;
    chk("wait_read_cycles", 64'(n_read_cycles - rc0), 64'(8));
    chk("wait_accepts", 64'(n_accept - acc0), 64'(3));

    // Address wrap on buffer 0
    buffer0_offset = 26'h3FF_FFF8;
    exp_frame(1'b0, 26'h3FF_FFF8);
    buffer0_empty = 1'b0;
    wait_clr(1'b0, 3);
    buffer0_empty = 1'b1;
    idle(3);

    // Stray beats in IDLE, then a gapped frame on buffer 1
    pc0 = pix_cnt;
    stray_en = 1'b1;
    idle(10);
    stray_en = 1'b0;
    idle(3);
    chk("stray_ignored", 64'(pix_cnt), 64'(pc0));
    gap_en = 1'b1;
    buffer1_offset = 26'h4000;
    exp_frame(1'b1, 26'h4000);
    buffer1_empty = 1'b0;
    wait_clr(1'b1, 3);
    buffer1_empty = 1'b1;
    gap_en = 1'b0;
    idle(3);
    chk("gapped_pix_count", 64'(pix_cnt - pc0), 64'(FW));

    // Reset mid-frame on buffer 0, then restart
    buffer0_offset = 26'h500;
    exp_frame(1'b0, 26'h500);
    pc0 = pix_cnt;
    c0 = clr0_cnt;
    buffer0_empty = 1'b0;
    for (int i = 0; i < 300 && (pix_cnt - pc0) < 20; i++) @(negedge clk);
    chk("reset_point", 64'((pix_cnt - pc0) >= 20), 64'(1));
    #1 reset_n = 1'b0;
    exp_pix.delete();
    exp_burst.delete();
    @(negedge clk);
    chk("midreset_outputs",
        64'({clear_buffer0, clear_buffer1, avm_read, avm_address, avm_burstcount,
             pix_valid, pix_sof, pix_eof, pix_buf, pix_data}), 64'(0));
    idle(2);
    chk("midreset_no_clear", 64'(clr0_cnt), 64'(c0));
    exp_frame(1'b0, 26'h500);
    reset_n = 1'b1;
    wait_clr(1'b0, c0 + 1);
    buffer0_empty = 1'b1;
    idle(5);
    chk("final_pix_drained", 64'(exp_pix.size()), 64'(0));
    chk("final_bursts_drained", 64'(exp_burst.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ddr3_frame_reader
